// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request/response bundle between the core and the data memory
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, addr, wdata, be, input ready, rdata, err);
    modport slave  (input req, we, addr, wdata, be, output ready, rdata, err);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory answering one load/store at a time
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic          h_we;
    logic [31:0]   h_addr, h_wdata;
    logic [3:0]    h_be;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          s_we, s_bad, to_resp;
    logic [31:0]   s_addr;
    logic [AW-1:0] s_idx;

    // Decode the live request in IDLE (needed when LATENCY=0) and the held one otherwise
    always_comb begin
        s_we    = (state == IDLE) ? bus.we : h_we;
        s_addr  = (state == IDLE) ? bus.addr : h_addr;
        s_idx   = s_addr[AW+1:2];
        s_bad   = (s_addr[1:0] != 2'b00) || (s_addr[31:AW+2] != '0);
        to_resp = (state_n == RESP);
    end

    // Next-state and wait counter
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (bus.req) begin
                cnt_n   = 4'(LATENCY);
                state_n = (LATENCY == 0) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_n   = cnt - 4'd1;
                state_n = (cnt == 4'd1) ? RESP : WAIT;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Capture the request when it is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_we    <= 1'b0;
            h_addr  <= '0;
            h_wdata <= '0;
            h_be    <= '0;
        end else if (state == IDLE && bus.req) begin
            h_we    <= bus.we;
            h_addr  <= bus.addr;
            h_wdata <= bus.wdata;
            h_be    <= bus.be;
        end
    end

    // Registered response, valid only for the single RESP cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ready <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ready <= to_resp;
            bus.err   <= to_resp && s_bad;
            bus.rdata <= (to_resp && !s_bad && !s_we) ? mem[s_idx] : '0;
        end
    end

    // Store commits on the edge that ends RESP; reset forces IDLE first, so an aborted store never lands
    always_ff @(posedge clk) begin
        if (state == RESP && h_we && !s_bad)
            for (int i = 0; i < 4; i++)
                if (h_be[i]) mem[s_idx][8*i +: 8] <= h_wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for the load/store responder at latencies 2, 0 and 15
module tb_dmem_responder;
    typedef struct {logic [31:0] rd; logic er;} exp_t;
    typedef struct {logic w; logic [31:0] a; logic [31:0] d; logic [3:0] b; logic [31:0] erd; logic eer;} stim_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    int          dsel = 0;
    logic        rdy, er;
    logic [31:0] rd;
    int          checks = 0, errors = 0;
    exp_t        q[$];

    always #5 clk = ~clk;

    dmem_responder_if m_if(), z_if(), f_if();

    assign m_if.req = req && (dsel == 0);
    assign z_if.req = req && (dsel == 1);
    assign f_if.req = req && (dsel == 2);
    assign m_if.we = we;    assign z_if.we = we;    assign f_if.we = we;
    assign m_if.addr = addr; assign z_if.addr = addr; assign f_if.addr = addr;
    assign m_if.wdata = wdata; assign z_if.wdata = wdata; assign f_if.wdata = wdata;
    assign m_if.be = be;    assign z_if.be = be;    assign f_if.be = be;
    assign rdy = (dsel == 0) ? m_if.ready : (dsel == 1) ? z_if.ready : f_if.ready;
    assign rd  = (dsel == 0) ? m_if.rdata : (dsel == 1) ? z_if.rdata : f_if.rdata;
    assign er  = (dsel == 0) ? m_if.err   : (dsel == 1) ? z_if.err   : f_if.err;

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2))  u_m (.clk(clk), .rst_n(rst_n), .bus(m_if));
    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(0))  u_z (.clk(clk), .rst_n(rst_n), .bus(z_if));
    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(15)) u_f (.clk(clk), .rst_n(rst_n), .bus(f_if));

    function automatic int lat_exp();
        return (dsel == 0) ? 3 : (dsel == 1) ? 1 : 16;
    endfunction

    task automatic issue(input stim_t s);
        req = 1'b1; we = s.w; addr = s.a; wdata = s.d; be = s.b;
        q.push_back('{s.erd, s.eer});
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic collect(output int lat, output logic [31:0] rd_o, output logic er_o, output logic [33:0] after);
        lat = 1;
        while (!rdy && lat < 40) begin @(posedge clk); #1; lat++; end
        rd_o = rd; er_o = er;
        @(posedge clk); #1;
        after = {rdy, er, rd};
    endtask

    task automatic test_reset();
        int lat; logic [31:0] r; logic e; logic [33:0] af; exp_t x;
        we = 1'b0; addr = 32'h2; req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({rdy, er, rd} !== 34'h0) begin errors++; $display("FAIL reset_hold[%0d] got ready=%b err=%b rdata=%h want all 0", c, rdy, er, rd); end
        end
        rst_n = 1'b1;
        q.push_back('{32'h0, 1'b1});
        @(posedge clk); #1;
        req = 1'b0;
        collect(lat, r, e, af);
        x = q.pop_front();
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL reset_first_lat got %0d want 3", lat); end
        checks++;
        if ({e, r} !== {x.er, x.rd}) begin errors++; $display("FAIL reset_first_resp got err=%b rdata=%h want err=%b rdata=%h", e, r, x.er, x.rd); end
    endtask

    task automatic test_round_trip();
        stim_t t[$]; int lat; logic [31:0] r; logic e; logic [33:0] af; exp_t x;
        t.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0});
        t.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0});
        t.push_back('{1'b1, 32'h14, 32'h0BADF00D, 4'hF, 32'h0, 1'b0});
        t.push_back('{1'b0, 32'h14, 32'hFFFFFFFF, 4'hF, 32'h0BADF00D, 1'b0});
        foreach (t[i]) begin
            issue(t[i]);
            collect(lat, r, e, af);
            x = q.pop_front();
            checks++;
            if (lat !== lat_exp()) begin errors++; $display("FAIL rt_lat[%0d] got %0d want %0d", i, lat, lat_exp()); end
            checks++;
            if ({e, r} !== {x.er, x.rd}) begin errors++; $display("FAIL rt_resp[%0d] got err=%b rdata=%h want err=%b rdata=%h", i, e, r, x.er, x.rd); end
            checks++;
            if (af !== 34'h0) begin errors++; $display("FAIL rt_after[%0d] got %h want 0", i, af); end
        end
    endtask

    task automatic test_byte_enables();
        stim_t t[$]; int lat; logic [31:0] r; logic e; logic [33:0] af; exp_t x;
        t.push_back('{1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0});
        t.push_back('{1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0});
        t.push_back('{1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0});
        t.push_back('{1'b1, 32'h20, 32'h99999999, 4'b0000, 32'h0, 1'b0});
        t.push_back('{1'b1, 32'h20, 32'h77665544, 4'b1000, 32'h0, 1'b0});
        t.push_back('{1'b0, 32'h20, 32'h0, 4'h0, 32'h77BB33DD, 1'b0});
        foreach (t[i]) begin
            issue(t[i]);
            collect(lat, r, e, af);
            x = q.pop_front();
            checks++;
            if ({e, r} !== {x.er, x.rd}) begin errors++; $display("FAIL be_resp[%0d] got err=%b rdata=%h want err=%b rdata=%h", i, e, r, x.er, x.rd); end
            checks++;
            if (af !== 34'h0) begin errors++; $display("FAIL be_after[%0d] got %h want 0", i, af); end
        end
    endtask

    task automatic test_errors();
        stim_t t[$]; int lat; logic [31:0] r; logic e; logic [33:0] af; exp_t x;
        t.push_back('{1'b1, 32'h0, 32'h5EED1234, 4'hF, 32'h0, 1'b0});
        t.push_back('{1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1});
        t.push_back('{1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1});
        t.push_back('{1'b1, 32'h1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1});
        t.push_back('{1'b0, 32'h40000000, 32'h0, 4'h0, 32'h0, 1'b1});
        t.push_back('{1'b0, 32'h0, 32'h0, 4'h0, 32'h5EED1234, 1'b0});
        t.push_back('{1'b0, 32'hFC, 32'h0, 4'h0, 32'h0, 1'b0});
        t[6].erd = 32'h0;
        foreach (t[i]) begin
            if (i == 6) begin
                t[6].w = 1'b1; t[6].d = 32'hC0FFEE00; t[6].b = 4'hF;
            end
            issue(t[i]);
            collect(lat, r, e, af);
            x = q.pop_front();
            checks++;
            if ({e, r} !== {x.er, x.rd}) begin errors++; $display("FAIL err_resp[%0d] got err=%b rdata=%h want err=%b rdata=%h", i, e, r, x.er, x.rd); end
            checks++;
            if (af !== 34'h0) begin errors++; $display("FAIL err_after[%0d] got %h want 0", i, af); end
        end
        issue('{1'b0, 32'hFC, 32'h0, 4'h0, 32'hC0FFEE00, 1'b0});
        collect(lat, r, e, af);
        x = q.pop_front();
        checks++;
        if ({e, r} !== {x.er, x.rd}) begin errors++; $display("FAIL err_last_word got err=%b rdata=%h want err=%b rdata=%h", e, r, x.er, x.rd); end
    endtask

    task automatic test_reset_mid();
        int lat, n; logic [31:0] r; logic e; logic [33:0] af; exp_t x; logic seen;
        issue('{1'b1, 32'h30, 32'h12345678, 4'hF, 32'h0, 1'b0});
        collect(lat, r, e, af);
        x = q.pop_front();
        req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'hCAFEF00D; be = 4'hF;
        @(posedge clk); #1;
        req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy, er} !== 2'b00) begin errors++; $display("FAIL mid_wait_reset got ready=%b err=%b want 0 0", rdy, er); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin @(posedge clk); #1; seen |= rdy; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL mid_wait_noready got ready seen=%b want 0", seen); end
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        n = 0;
        while (!rdy && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL mid_resp_reach got ready=%b want 1", rdy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy, er, rd} !== 34'h0) begin errors++; $display("FAIL mid_resp_reset got %h want 0", {rdy, er, rd}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue('{1'b0, 32'h30, 32'h0, 4'h0, 32'h12345678, 1'b0});
        collect(lat, r, e, af);
        x = q.pop_front();
        checks++;
        if ({e, r} !== {x.er, x.rd}) begin errors++; $display("FAIL mid_load got err=%b rdata=%h want err=%b rdata=%h", e, r, x.er, x.rd); end
    endtask

    task automatic test_latency();
        int lat; logic [31:0] r; logic e; logic [33:0] af; exp_t x;
        for (int d = 1; d < 3; d++) begin
            dsel = d;
            issue('{1'b1, 32'h8, 32'h55AA0000 + d, 4'hF, 32'h0, 1'b0});
            collect(lat, r, e, af);
            x = q.pop_front();
            checks++;
            if (lat !== lat_exp()) begin errors++; $display("FAIL lat_store[d%0d] got %0d want %0d", d, lat, lat_exp()); end
            issue('{1'b0, 32'h8, 32'h0, 4'h0, 32'h55AA0000 + d, 1'b0});
            collect(lat, r, e, af);
            x = q.pop_front();
            checks++;
            if (lat !== lat_exp()) begin errors++; $display("FAIL lat_load[d%0d] got %0d want %0d", d, lat, lat_exp()); end
            checks++;
            if ({e, r} !== {x.er, x.rd}) begin errors++; $display("FAIL lat_data[d%0d] got err=%b rdata=%h want err=%b rdata=%h", d, e, r, x.er, x.rd); end
            checks++;
            if (af !== 34'h0) begin errors++; $display("FAIL lat_after[d%0d] got %h want 0", d, af); end
        end
        dsel = 0;
    endtask

    task automatic test_back_to_back();
        int k, n; logic dbl;
        for (int d = 0; d < 3; d++) begin
            dsel = d;
            req = 1'b1; we = 1'b0; addr = 32'h22;
            k = 0;
            do begin @(posedge clk); #1; k++; end while (!rdy && k < 40);
            n = 0; dbl = 1'b0;
            do begin
                @(posedge clk); #1; n++;
                if (n == 1) dbl = rdy;
            end while (!rdy && n < 40);
            req = 1'b0;
            checks++;
            if (dbl !== 1'b0) begin errors++; $display("FAIL b2b_double[d%0d] got ready twice in a row want single", d); end
            checks++;
            if (n !== lat_exp() + 1) begin errors++; $display("FAIL b2b_spacing[d%0d] got %0d want %0d", d, n, lat_exp() + 1); end
            checks++;
            if (er !== 1'b1) begin errors++; $display("FAIL b2b_err[d%0d] got %b want 1", d, er); end
            @(posedge clk); #1;
        end
        dsel = 0;
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_byte_enables();
        test_errors();
        test_reset_mid();
        test_latency();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
